// File: rtl/arb_req_agent.sv
// Requester-side agent: per-client FIFOs feed an external combinational arbiter; granted head goes to one valid/ready output.
// Optional ARB_AGENT_GNT_CHECK_EN: illegal grants are ignored and latch a sticky err flag.
module arb_req_agent #(
    parameter int N     = 8,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*DW-1:0]      in_data,
    output logic [N-1:0]         in_ready,
    output logic [N-1:0]         req,
    input  logic [N-1:0]         gnt,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_src,
    input  logic                 out_ready,
    output logic                 err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(N);
    localparam logic [N-1:0]  ONE_N = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    logic [DW-1:0] mem_q    [N][DEPTH];
    logic [PW-1:0] wr_ptr_q [N];
    logic [PW-1:0] rd_ptr_q [N];
    logic [CW-1:0] cnt_q    [N];

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [SW-1:0] out_src_q, out_src_d;

    logic          accept;
    logic [N-1:0]  nonempty;
    logic [N-1:0]  push;
    logic [N-1:0]  pop;
    logic          grant_vld;
    logic [SW-1:0] grant_src;
    logic [DW-1:0] grant_data;

    always_comb begin
        accept = !out_valid_q || out_ready;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = (cnt_q[i] != FULL);
            nonempty[i] = (cnt_q[i] != '0);
        end
        req  = nonempty & {N{accept}};
        push = in_valid & in_ready;
    end

`ifdef ARB_AGENT_GNT_CHECK_EN
    logic gnt_onehot, gnt_legal, gnt_illegal, err_q;

    always_comb begin
        gnt_onehot  = (gnt != '0) && ((gnt & (gnt - ONE_N)) == '0);
        gnt_legal   = gnt_onehot && ((gnt & ~req) == '0);
        gnt_illegal = (gnt != '0) && !gnt_legal;
        pop         = gnt_legal ? gnt : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (gnt_illegal) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic [N-1:0] gnt_eff;

    // Multi-hot grants resolve to the lowest set bit, same as the fixed-priority arbiter.
    always_comb begin
        gnt_eff = gnt & req;
        pop     = gnt_eff & (~gnt_eff + ONE_N);
    end

    assign err = 1'b0;
`endif

    always_comb begin
        grant_vld  = (pop != '0);
        grant_src  = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (pop[i]) begin
                grant_src  = SW'(i);
                grant_data = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (accept) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d = grant_data;
                out_src_d  = grant_src;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
                end
                cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent with a bench-side fixed-priority / round-robin / forced arbiter.
module tb_arb_req_agent;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    localparam int G_FORCE = 0;
    localparam int G_FP    = 1;
    localparam int G_RR    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    out_src;
    logic          out_ready;
    logic          err;

    int            gmode;
    logic [N-1:0]  gforce;
    int            rr_last = N - 1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arb_req_agent #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .err       (err)
    );

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int last);
        logic [N-1:0] g;
        g = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (r[idx] && g == '0) g[idx] = 1'b1;
        end
        return g;
    endfunction

    always_comb begin
        gnt = '0;
        case (gmode)
            G_FP:    gnt = req & (~req + {{(N-1){1'b0}}, 1'b1});
            G_RR:    gnt = rr_pick(req, rr_last);
            default: gnt = gforce;
        endcase
    end

    always @(posedge clk) begin
        if (gmode == G_RR) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) rr_last <= i;
            end
        end
    end

    function automatic logic [DW-1:0] dval(input int c, input int e);
        return 32'hC000_0000 + DW'(c * 256) + DW'(e);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int order [3];
        order[0] = 1; order[1] = 2; order[2] = 6;

        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        gmode = G_FORCE; gforce = '0;
        @(negedge clk); @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'hFF);
        check("rst_req", 64'(req), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_src", 64'(out_src), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        rst = 1'b0;
        tick();

        // Single client through a fixed-priority arbiter
        gmode = G_FP; out_ready = 1'b1;
        in_valid = 8'h08; in_data[3*DW +: DW] = 32'hA5A5_0001;
        #1 check("t1_req_before", 64'(req), 64'h0);
        tick();
        in_valid = '0;
        #1 check("t1_req", 64'(req), 64'h08);
        check("t1_ov_early", 64'(out_valid), 64'h0);
        tick();
        check("t1_ov", 64'(out_valid), 64'h1);
        check("t1_data", 64'(out_data), 64'hA5A5_0001);
        check("t1_src", 64'(out_src), 64'h3);
        check("t1_req_empty", 64'(req), 64'h0);
        tick();
        check("t1_ov_clear", 64'(out_valid), 64'h0);

        // Fill client 0 beyond capacity with the arbiter idle
        gmode = G_FORCE; gforce = '0; out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            in_valid = 8'h01; in_data[0 +: DW] = 32'hD0D0_0000 + DW'(j);
            #1 check("t2_in_ready", 64'(in_ready[0]), (j < 4) ? 64'h1 : 64'h0);
            tick();
        end
        in_valid = '0;
        #1 check("t2_req_full", 64'(req), 64'h01);
        check("t2_ov_idle", 64'(out_valid), 64'h0);
        gmode = G_FP;
        tick();
        check("t2_ov", 64'(out_valid), 64'h1);
        check("t2_d0", 64'(out_data), 64'hD0D0_0000);
        check("t2_src", 64'(out_src), 64'h0);
        check("t2_req_stall", 64'(req), 64'h0);
        check("t2_in_ready_after_pop", 64'(in_ready[0]), 64'h1);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("bp_ov", 64'(out_valid), 64'h1);
            check("bp_data", 64'(out_data), 64'hD0D0_0000);
            check("bp_req", 64'(req), 64'h0);
        end
        out_ready = 1'b1;
        #1 check("bp_req_release", 64'(req), 64'h01);
        for (int j = 1; j < 4; j++) begin
            tick();
            check("t2_drain_ov", 64'(out_valid), 64'h1);
            check("t2_drain_data", 64'(out_data), 64'hD0D0_0000 + 64'(j));
        end
        check("t2_req_empty", 64'(req), 64'h0);
        tick();
        check("t2_ov_clear", 64'(out_valid), 64'h0);

        // Round-robin across clients 1, 2, 6
        gmode = G_FORCE; gforce = '0;
        for (int e = 0; e < 2; e++) begin
            in_valid = 8'h46;
            in_data[1*DW +: DW] = dval(1, e);
            in_data[2*DW +: DW] = dval(2, e);
            in_data[6*DW +: DW] = dval(6, e);
            tick();
        end
        in_valid = '0;
        gmode = G_RR;
        #1 check("t3_req", 64'(req), 64'h46);
        for (int s = 0; s < 6; s++) begin
            tick();
            check("t3_ov", 64'(out_valid), 64'h1);
            check("t3_src", 64'(out_src), 64'(order[s % 3]));
            check("t3_data", 64'(out_data), 64'(dval(order[s % 3], s / 3)));
        end
        tick();
        check("t3_ov_clear", 64'(out_valid), 64'h0);

        // Multi-hot grant
        gmode = G_FORCE; gforce = '0;
        in_valid = 8'h06;
        in_data[1*DW +: DW] = dval(1, 9);
        in_data[2*DW +: DW] = dval(2, 9);
        tick();
        in_valid = '0;
        #1 check("t4_req", 64'(req), 64'h06);
        gforce = 8'h06;
        tick();
        gforce = '0;
`ifdef ARB_AGENT_GNT_CHECK_EN
        check("t4_ov_ignored", 64'(out_valid), 64'h0);
        check("t4_err", 64'(err), 64'h1);
        #1 check("t4_no_pop", 64'(req), 64'h06);
        tick();
        check("t4_err_sticky", 64'(err), 64'h1);
        gmode = G_FP;
        tick();
        check("t4_src1", 64'(out_src), 64'h1);
        check("t4_data1", 64'(out_data), 64'(dval(1, 9)));
`else
        check("t4_ov", 64'(out_valid), 64'h1);
        check("t4_src_low", 64'(out_src), 64'h1);
        check("t4_data_low", 64'(out_data), 64'(dval(1, 9)));
        check("t4_err_zero", 64'(err), 64'h0);
        tick();
        check("t4_ov_clear", 64'(out_valid), 64'h0);
        check("t4_req_rest", 64'(req), 64'h04);
        gmode = G_FP;
`endif
        tick();
        check("t4_ov2", 64'(out_valid), 64'h1);
        check("t4_src2", 64'(out_src), 64'h2);
        check("t4_data2", 64'(out_data), 64'(dval(2, 9)));
        tick();
        check("t4_ov_end", 64'(out_valid), 64'h0);

        // Asynchronous reset mid-burst
        gmode = G_FORCE; gforce = '0; out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_valid = 8'h10; in_data[4*DW +: DW] = dval(4, j);
            tick();
        end
        in_valid = '0;
        gmode = G_FP;
        tick();
        check("t5_ov", 64'(out_valid), 64'h1);
        check("t5_data", 64'(out_data), 64'(dval(4, 0)));
        check("t5_req_stall", 64'(req), 64'h0);
        rst = 1'b1;
        #1 check("t5_ov_rst", 64'(out_valid), 64'h0);
        check("t5_req_rst", 64'(req), 64'h0);
        check("t5_in_ready_rst", 64'(in_ready), 64'hFF);
        check("t5_data_rst", 64'(out_data), 64'h0);
        check("t5_err_rst", 64'(err), 64'h0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        tick();
        check("t5_ov_after", 64'(out_valid), 64'h0);
        check("t5_req_after", 64'(req), 64'h0);
        tick();
        check("t5_ov_after2", 64'(out_valid), 64'h0);
        check("t5_src_after", 64'(out_src), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_req_agent.md
Name: arb_req_agent

Overview:
Requester-side companion to the team's fixed-priority and round-robin arbiters. It buffers traffic from N clients in per-client FIFOs and drives the req vector into an external combinational arbiter. It consumes the returned one-hot gnt and forwards the granted entry, tagged with its source index, to a single valid/ready output.

Parameters:
N, 8, number of clients (= arbiter width), >=2
DW, 32, payload width per client
DEPTH, 4, entries per client FIFO, power of 2, >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  N  per-client push request
in_data  in  N*DW  client i payload at [i*DW +: DW]
in_ready  out  N  per-client FIFO not full
req  out  N  request vector to arbiter
gnt  in  N  grant vector from arbiter, same-cycle (combinational) response to req
out_valid  out  1  output register holds data
out_data  out  DW  granted payload
out_src  out  $clog2(N)  index of granted client
out_ready  in  1  downstream accept
err  out  1  sticky illegal-grant flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, FIFO pointers 0, out_valid=0, out_data=0, out_src=0, err=0. in_ready=all ones after reset. Mid-operation reset discards all buffered and output data.
- Client FIFO i:
  - Push when in_valid[i] & in_ready[i].
  - in_ready[i] = (count_i != DEPTH), registered-count based. There is no bypass when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both take effect.
- Output stage: one register. accept = !out_valid | out_ready.
- req[i] = (count_i != 0) & accept. req is combinational from registered count and out_valid/out_ready.
  - A push at cycle t raises req at t+1 at the earliest.
  - req is all zero while the output is stalled.
- A grant is legal when gnt is one-hot and gnt is a subset of req.
- On a legal grant to client k:
  - Pop FIFO k head.
  - Next edge: out_data=head_k, out_src=k, out_valid=1.
  - Minimum latency from push to out_valid is 2 cycles.
- gnt == 0 with accept: no pop. out_valid clears next edge if out_ready was 1.
- Output handshake: out_valid/out_data/out_src are held stable while out_valid & !out_ready. They are cleared or replaced only on out_ready. Back-to-back grants sustain 1 transfer per cycle while out_ready=1.
- Wrap-around: FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Order: per-client FIFO order is preserved. Cross-client order is decided solely by the arbiter.

Optional Feature:
- Macro: ARB_AGENT_GNT_CHECK_EN.
- Defined: an illegal grant (not one-hot, or a bit set outside req) is ignored: no pop, no output load. err sets on the next edge and stays 1 until rst.
- Undefined: err is tied 0. The effective grant is gnt & req. If that is multi-hot, the lowest set bit wins, matching the fixed-priority convention.

Test Plan:
- Single client: push 0xA5A5_0001 on client 3, fixed-priority arbiter attached, out_ready=1 -> req=8'h08 one cycle later, out_valid with out_data=0xA5A5_0001, out_src=3 two cycles after the push.
- Full/empty: push 5 entries to client 0 with out_ready=0 -> in_ready[0] drops after the 4th push. The 5th push is not accepted, and req is 0 while out_valid=1. Then raise out_ready -> 4 entries drain in FIFO order, one per cycle.
- Round-robin fairness: clients 1, 2, 6 each hold 2 entries, RR arbiter, out_ready=1 -> out_src sequence 1,2,6,1,2,6 with no idle cycles.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data and out_src stable, no pops, req=0. On out_ready=1 the next grant loads in the same cycle.
- Illegal grant (macro defined): force gnt=8'h06 while req=8'h06 -> no pop, out_valid unchanged, err=1 next cycle and sticky. Macro undefined: client 1 is popped and err stays 0.
- Async reset mid-burst: assert rst with 3 entries queued and out_valid=1 -> out_valid=0 and req=0 immediately, in_ready=8'hFF, no stale data after release.
